// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  localparam int DATA_W = 8;

  // Line bits per frame: start + data + optional parity + stop.
  function automatic int bits(input parity_e par);
    return (par == PAR_NONE) ? DATA_W + 2 : DATA_W + 3;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered read port; a pop on a full FIFO frees the slot for a same-cycle push.
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        pop_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_xcvr.sv
// 8-bit UART transceiver: TX FIFO feeding a serializer, rxd deserializer feeding an RX FIFO.
module uart_fifo_xcvr
  import uart_pkg::*;
#(
  parameter int BR_DIV  = 868,
  parameter int PARITY  = 0,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_write,
  output logic               tx_full,
  output logic               tx_busy,
  output logic               txd,
  input  logic               rxd,
  input  logic               rx_read,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_par_err,
  output logic               rx_empty,
  output logic [FIFO_AW:0]   rx_count,
  output logic               rx_busy,
  output logic               rx_overflow
);

  localparam parity_e         PAR       = parity_e'(PARITY);
  localparam int              TX_BITS   = bits(PAR);
  localparam int              RX_BITS   = TX_BITS - 1;
  localparam int              BW        = $clog2(BR_DIV);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BR_DIV - 1);
  localparam logic [BW-1:0]   BAUD_MID  = BW'(BR_DIV / 2);

  function automatic logic par_bit(input logic [DATA_W-1:0] d);
    return (PAR == PAR_ODD) ? ~^d : ^d;
  endfunction

  logic              tx_empty;
  logic              tx_pop;
  logic              start;
  logic [DATA_W-1:0] tx_head;
  logic [FIFO_AW:0]  tx_count;
  logic [10:0]       tx_shift;
  logic [BW-1:0]     tx_baud;
  logic [3:0]        tx_bit;

  uart_sync_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_write), .push_data(tx_data),
    .pop(tx_pop), .pop_data(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // Pop one cycle ahead of 'start' so the registered FIFO head is ready to load.
  assign tx_pop = !tx_empty && !tx_busy && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start    <= 1'b0;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_baud  <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      start <= tx_pop;
      txd   <= tx_busy ? tx_shift[0] : 1'b1;
      if (start) begin
        tx_shift <= {1'b1, (PAR == PAR_NONE) ? 1'b1 : par_bit(tx_head), tx_head, 1'b0};
        tx_busy  <= 1'b1;
        tx_baud  <= '0;
        tx_bit   <= '0;
      end else if (tx_busy) begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud  <= '0;
          tx_shift <= {1'b1, tx_shift[10:1]};
          if (tx_bit == 4'(TX_BITS - 1)) begin
            tx_bit  <= '0;
            tx_busy <= 1'b0;
          end else begin
            tx_bit <= tx_bit + 1'b1;
          end
        end else begin
          tx_baud <= tx_baud + 1'b1;
        end
      end
    end
  end

  logic          rxd_s1;
  logic          rxd_s2;
  logic          rxd_prev;
  logic          rx_fall;
  logic          rx_push;
  logic          rx_full;
  logic          par_err;
  logic [9:0]    rx_shift;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [8:0]    rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  assign rx_fall = rxd_prev && !rxd_s2;
  assign rx_push = rx_busy && (rx_baud == BAUD_LAST) && (rx_bit == 4'(RX_BITS - 1));
  // Samples enter at the top of the active window so data always lands in [8:1], parity in [9].
  assign par_err = (PAR == PAR_NONE) ? 1'b0 : (rx_shift[9] != par_bit(rx_shift[8:1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy     <= 1'b0;
      rx_shift    <= '0;
      rx_baud     <= '0;
      rx_bit      <= '0;
      rx_overflow <= 1'b0;
    end else begin
      rx_overflow <= rx_push && rx_full && !rx_read;
      if (!rx_busy) begin
        if (rx_fall) begin
          rx_busy <= 1'b1;
          rx_baud <= '0;
          rx_bit  <= '0;
        end
      end else begin
        if (rx_baud == BAUD_MID)
          rx_shift <= (rx_shift >> 1) | (10'(rxd_s2) << (RX_BITS - 1));
        if (rx_baud == BAUD_LAST) begin
          rx_baud <= '0;
          if (rx_bit == 4'(RX_BITS - 1)) begin
            rx_bit  <= '0;
            rx_busy <= 1'b0;
          end else begin
            rx_bit <= rx_bit + 1'b1;
          end
        end else begin
          rx_baud <= rx_baud + 1'b1;
        end
      end
    end
  end

  uart_sync_fifo #(.DW(DATA_W + 1), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_data({par_err, rx_shift[8:1]}),
    .pop(rx_read), .pop_data(rx_q),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  assign rx_data    = rx_q[7:0];
  assign rx_par_err = rx_q[8];

  logic lint_unused;
  assign lint_unused = ^{tx_count, rx_shift[0]};

endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// Scoreboard bench for uart_fifo_xcvr: loopback and externally driven frames against a frame-level model.
module tb_uart_fifo_xcvr;

  localparam int BR_DIV    = 108;
  localparam int PARITY    = 1;
  localparam int FIFO_AW   = 4;
  localparam int FRAME_CYC = 11 * BR_DIV;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [7:0]         tx_data = 8'h00;
  logic               tx_write = 1'b0;
  logic               tx_full, tx_busy, txd;
  logic               rxd;
  logic               ext_rxd = 1'b1;
  logic               loop = 1'b1;
  logic               rx_read = 1'b0;
  logic [7:0]         rx_data;
  logic               rx_par_err, rx_empty, rx_busy, rx_overflow;
  logic [FIFO_AW:0]   rx_count;

  assign rxd = loop ? txd : ext_rxd;

  uart_fifo_xcvr #(.BR_DIV(BR_DIV), .PARITY(PARITY), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full), .tx_busy(tx_busy), .txd(txd),
    .rxd(rxd), .rx_read(rx_read), .rx_data(rx_data), .rx_par_err(rx_par_err),
    .rx_empty(rx_empty), .rx_count(rx_count), .rx_busy(rx_busy), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         ovf_cnt = 0;
  bit         abort_chk = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] tx_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Odd parity: the parity bit makes the count of ones across data+parity odd.
  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  // Host-side pop monitor.
  logic pop_d = 1'b0;
  always @(negedge clk) begin
    if (pop_d) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_pop: got 0x%0h, expected no byte", {rx_par_err, rx_data});
      end else begin
        check("rx_pop", 32'({rx_par_err, rx_data}), 32'(exp_q.pop_front()));
      end
    end
    pop_d = rst_n && rx_read && !rx_empty;
    if (rx_overflow) ovf_cnt++;
  end

  // Frame duration monitor.
  int busy_run = 0;
  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else if (tx_busy) busy_run++;
    else if (busy_run != 0) begin
      if (!abort_chk) check("tx_busy_len", 32'(busy_run), 32'(FRAME_CYC));
      busy_run = 0;
    end
  end

  // Line monitor: decode txd at mid-bit and compare with the expected frame.
  initial begin : tx_line_mon
    logic        prev;
    logic [10:0] f;
    logic [7:0]  e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !txd) begin
        repeat (BR_DIV / 2 - 1) @(negedge clk);
        f[0] = txd;
        for (int b = 1; b < 11; b++) begin
          repeat (BR_DIV) @(negedge clk);
          f[b] = txd;
        end
        if (!abort_chk) begin
          if (tx_exp.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL txd_frame: got 0x%0h, expected no frame", f);
          end else begin
            e = tx_exp.pop_front();
            check("txd_frame", 32'(f), 32'({1'b1, odd_par(e), e, 1'b0}));
          end
        end
      end
      prev = txd;
    end
  end

  task automatic push_tx(input logic [7:0] d);
    @(posedge clk); #1;
    tx_data = d;
    tx_write = 1'b1;
    tx_exp.push_back(d);
    exp_q.push_back({1'b0, d});
    @(posedge clk); #1;
    tx_write = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip);
    logic [10:0] f;
    f = {1'b1, odd_par(d) ^ flip, d, 1'b0};
    exp_q.push_back({flip, d});
    @(posedge clk); #1;
    for (int b = 0; b < 11; b++) begin
      ext_rxd = f[b];
      repeat (BR_DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_count != (FIFO_AW+1)'(n) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("rx_count", 32'(rx_count), 32'(n));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 rx_read = 1'b1;
      @(posedge clk); #1 rx_read = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ovf0;
    int busy_seen;
    int low_seen;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_rx_data", 32'({rx_par_err, rx_data}), 32'd0);
    check("rst_rx_overflow", 32'(rx_overflow), 32'd0);
    rst_n = 1'b1;

    // Two queued bytes go out back to back.
    @(posedge clk); #1;
    tx_data = 8'hA5; tx_write = 1'b1;
    tx_exp.push_back(8'hA5); exp_q.push_back({1'b0, 8'hA5});
    @(posedge clk); #1;
    tx_data = 8'hC3;
    tx_exp.push_back(8'hC3); exp_q.push_back({1'b0, 8'hC3});
    @(posedge clk); #1;
    tx_write = 1'b0;
    wait_rx(2, 2 * FRAME_CYC + 600);
    drain(2);

    repeat (2500) @(posedge clk);
    #1;
    push_tx(8'h37);
    wait_rx(1, FRAME_CYC + 300);
    drain(1);

    for (int i = 0; i < 6; i++) begin
      push_tx(8'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_rx(6, 6 * FRAME_CYC + 1000);
    drain(6);

    // Externally driven frames, including parity errors.
    loop = 1'b0;
    send_frame(8'h5A, 1'b1);
    wait_rx(1, 500);
    drain(1);
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'($urandom_range(0, 1)));
    wait_rx(4, 500);
    drain(4);
    loop = 1'b1;

    // Burst of 18 pushes: 17 accepted, RX overflows on the 17th.
    ovf0 = ovf_cnt;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i == 17) check("tx_full_after_17", 32'(tx_full), 32'd1);
      d = 8'($urandom);
      tx_data = d;
      tx_write = 1'b1;
      if (i < 17) tx_exp.push_back(d);
      if (i < 16) exp_q.push_back({1'b0, d});
    end
    @(posedge clk); #1;
    tx_write = 1'b0;
    wait_rx(16, 17 * FRAME_CYC + 2000);
    for (int c = 0; c < 3000 && tx_exp.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (100) @(posedge clk);
    #1;
    check("tx_exp_drained", 32'(tx_exp.size()), 32'd0);
    check("rx_count_full", 32'(rx_count), 32'd16);
    check("rx_overflow_pulses", 32'(ovf_cnt - ovf0), 32'd1);
    drain(16);
    check("rx_empty_after_drain", 32'(rx_empty), 32'd1);

    // Reset in the middle of a looped frame.
    abort_chk = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h96; tx_write = 1'b1;
    @(posedge clk); #1;
    tx_write = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("mid_tx_busy", 32'(tx_busy), 32'd1);
    check("mid_rx_busy", 32'(rx_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_txd", 32'(txd), 32'd1);
    check("abort_tx_busy", 32'(tx_busy), 32'd0);
    check("abort_rx_busy", 32'(rx_busy), 32'd0);
    check("abort_rx_empty", 32'(rx_empty), 32'd1);
    check("abort_rx_count", 32'(rx_count), 32'd0);
    check("abort_tx_full", 32'(tx_full), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    busy_seen = 0;
    low_seen = 0;
    repeat (1500) begin
      @(negedge clk);
      if (tx_busy) busy_seen++;
      if (!txd) low_seen++;
    end
    check("post_abort_tx_idle", 32'(busy_seen), 32'd0);
    check("post_abort_txd_high", 32'(low_seen), 32'd0);
    check("post_abort_rx_count", 32'(rx_count), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
